// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-subset CPU (FETCH/DECODE/EXEC/MEM/WB) with an
// internal 32x32 register file and one shared instruction/data port using req/ack.
// Optional feature macro: MIPS_MC_JUMP_EN makes opcode 000010 (j) a legal instruction.
module mips_multicycle_core #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [CNT_W-1:0]  retired,
    output logic              illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_retired;
    logic [31:0]       r_ir, r_a, r_b, r_imm, r_aluout, r_mdr;
    logic [31:0]       r_regs [32];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_wb_dst;
    logic              w_funct_ok, w_is_jump, w_legal, w_req, w_xfer, w_retire;
    logic [31:0]       w_alu, w_wb_data;
    logic [ADDR_W-1:0] w_pc_plus4, w_branch, w_pc_next;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_branch   = w_pc_plus4 + ADDR_W'({r_imm[29:0], 2'b00});
    assign w_wb_dst   = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data  = (w_op == OP_LW) ? r_mdr : r_aluout;

`ifdef MIPS_MC_JUMP_EN
    logic [31:0]       w_jfull;
    // Upper PC field comes from pc+4; masking then truncating also covers ADDR_W <= 28.
    assign w_jfull   = (32'(w_pc_plus4) & 32'hF000_0000) | {4'b0000, r_ir[25:0], 2'b00};
    assign w_is_jump = (w_op == OP_J);
`else
    assign w_is_jump = 1'b0;
`endif

    assign w_legal = ((w_op == OP_RTYPE) && w_funct_ok) || (w_op == OP_ADDI) ||
                     (w_op == OP_LW) || (w_op == OP_SW) || (w_op == OP_BEQ) || w_is_jump;

    // reset wins over the state decode so a handshake is abandoned the instant rst rises
    assign mem_req   = w_req && !rst;
    assign mem_wdata = r_b;
    assign pc_out    = r_pc;
    assign retired   = r_retired;
    assign w_xfer    = w_req && mem_ack;

    // R-type ALU and funct legality
    always_comb begin
        w_funct_ok = 1'b1;
        w_alu      = '0;
        case (w_funct)
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = {31'b0, ($signed(r_a) < $signed(r_b))};
            default: w_funct_ok = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // next state, memory port controls, retire strobe and next PC
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        illegal   = 1'b0;
        w_retire  = 1'b0;
        w_pc_next = w_pc_plus4;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (w_xfer) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!w_legal) begin
                    illegal  = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if ((w_op == OP_BEQ) || w_is_jump) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                    if ((w_op == OP_BEQ) && (r_a == r_b)) w_pc_next = w_branch;
`ifdef MIPS_MC_JUMP_EN
                    if (w_is_jump) w_pc_next = ADDR_W'(w_jfull);
`endif
                end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_req    = 1'b1;
                mem_we   = (w_op == OP_SW);
                mem_addr = r_aluout[ADDR_W-1:0];
                if (w_xfer) begin
                    w_retire = (w_op == OP_SW);
                    w_next   = (w_op == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        if (rst) mem_we = 1'b0;
    end

    // datapath registers, register file, PC and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC[ADDR_W-1:0];
            r_retired <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH:  if (w_xfer) r_ir <= mem_rdata;
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                end
                S_EXEC:   r_aluout <= (w_op == OP_RTYPE) ? w_alu : (r_a + r_imm);
                S_MEM:    if (w_xfer && (w_op == OP_LW)) r_mdr <= mem_rdata;
                S_WB:     if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_wb_data;
                default:  ;
            endcase
            if (w_retire) begin
                r_pc      <= w_pc_next;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: table of small programs plus hand-written stall,
// branch-loop and reset sequences. Stores seen on the memory port are checked against
// an expected-store queue; register contents are observed by storing them to memory.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ack, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, retired;

    always #5 clk = ~clk;

    mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc_out(pc_out), .retired(retired), .illegal(illegal)
    );

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } st_t;
    st_t exp_q[$];
    st_t got_q[$];

    // memory model: program image overlaid by words written by the CPU
    logic [31:0] pmem [128];
    logic [31:0] dmem [128];
    logic        dvalid [128];
    int          mem_wait = 0;
    int          wait_cnt;
    logic [6:0]  w_idx;

    assign w_idx     = mem_addr[8:2];
    assign mem_ack   = mem_req && (wait_cnt >= mem_wait);
    assign mem_rdata = dvalid[w_idx] ? dmem[w_idx] : pmem[w_idx];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            for (int i = 0; i < 128; i++) dvalid[i] <= 1'b0;
        end else if (mem_req) begin
            if (mem_ack) begin
                wait_cnt <= 0;
                if (mem_we) begin
                    dmem[w_idx]   <= mem_wdata;
                    dvalid[w_idx] <= 1'b1;
                    got_q.push_back({mem_addr, mem_wdata});
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc, ill_cnt;
    logic        prev_stall;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ienc(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] renc(input int rs, input int rt, input int rd, input int fn);
        return {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn[5:0]};
    endfunction

    // one clock; sample 1 time unit after the edge, check stall stability, drain stores
    task automatic step();
        st_t g, e;
        @(posedge clk);
        #1;
        cyc++;
        if (illegal) ill_cnt++;
        if (prev_stall) begin
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", mem_addr, prev_addr);
            check("stall_we", 32'(mem_we), 32'(prev_we));
            check("stall_wdata", mem_wdata, prev_wdata);
        end
        prev_stall = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL store_unexpected: got addr %h data %h, expected no store", g.addr, g.data);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", g.addr, e.addr);
                check("store_data", g.data, e.data);
            end
        end
    endtask

    task automatic assert_rst(input int w);
        rst = 1'b1;
        mem_wait = w;
        repeat (2) @(posedge clk);
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 128; i++) pmem[i] = '0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        ill_cnt = 0;
        prev_stall = 1'b0;
    endtask

    typedef struct {
        string           name;
        int              wait_cyc, n_ret, exp_cyc, exp_ill, n_prog, n_st;
        logic [31:0]     exp_pc;
        logic [11:0][31:0] prog;
        logic [3:0][31:0]  st_addr;
        logic [3:0][31:0]  st_data;
    } case_t;

    case_t tbl [8];
    int    n_tbl = 0;

    task automatic new_case(input string nm, input int w, input int nr, input int nc,
                            input logic [31:0] pc, input int ill);
        tbl[n_tbl].name     = nm;
        tbl[n_tbl].wait_cyc = w;
        tbl[n_tbl].n_ret    = nr;
        tbl[n_tbl].exp_cyc  = nc;
        tbl[n_tbl].exp_pc   = pc;
        tbl[n_tbl].exp_ill  = ill;
        tbl[n_tbl].n_prog   = 0;
        tbl[n_tbl].n_st     = 0;
        tbl[n_tbl].prog     = '0;
        tbl[n_tbl].st_addr  = '0;
        tbl[n_tbl].st_data  = '0;
        n_tbl++;
    endtask

    task automatic ins(input logic [31:0] w);
        tbl[n_tbl-1].prog[tbl[n_tbl-1].n_prog] = w;
        tbl[n_tbl-1].n_prog++;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        tbl[n_tbl-1].st_addr[tbl[n_tbl-1].n_st] = a;
        tbl[n_tbl-1].st_data[tbl[n_tbl-1].n_st] = d;
        tbl[n_tbl-1].n_st++;
    endtask

    task automatic run_case(input int k);
        assert_rst(tbl[k].wait_cyc);
        for (int i = 0; i < tbl[k].n_prog; i++) pmem[i] = tbl[k].prog[i];
        for (int i = 0; i < tbl[k].n_st; i++) exp_q.push_back({tbl[k].st_addr[i], tbl[k].st_data[i]});
        release_rst();
        while ((retired != 32'(tbl[k].n_ret)) && (cyc < 500)) step();
        check({tbl[k].name, "/retired"}, retired, 32'(tbl[k].n_ret));
        check({tbl[k].name, "/cycles"}, 32'(cyc), 32'(tbl[k].exp_cyc));
        check({tbl[k].name, "/pc"}, pc_out, tbl[k].exp_pc);
        check({tbl[k].name, "/illegal_cycles"}, 32'(ill_cnt), 32'(tbl[k].exp_ill));
        check({tbl[k].name, "/stores_missing"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cum [5];
        #1;
        // name, wait, retires, cycles, final pc, illegal cycles
        new_case("alu_basic", 0, 6, 24, 32'h18, 0);
        ins(ienc(8, 0, 1, 5)); ins(ienc(8, 0, 2, -3)); ins(renc(1, 2, 3, 'h20)); ins(renc(2, 1, 4, 'h2A));
        ins(ienc(43, 0, 3, 'h100)); ins(ienc(43, 0, 4, 'h104));
        st(32'h100, 32'd2); st(32'h104, 32'd1);

        new_case("alu_logic", 0, 10, 40, 32'h28, 0);
        ins(ienc(8, 0, 1, 'h0F0F)); ins(ienc(8, 0, 2, 'h00FF)); ins(renc(1, 2, 3, 'h22));
        ins(renc(1, 2, 4, 'h24)); ins(renc(1, 2, 5, 'h25)); ins(renc(1, 2, 6, 'h2A));
        ins(ienc(43, 0, 3, 'h100)); ins(ienc(43, 0, 4, 'h104)); ins(ienc(43, 0, 5, 'h108)); ins(ienc(43, 0, 6, 'h10C));
        st(32'h100, 32'h0E10); st(32'h104, 32'h000F); st(32'h108, 32'h0FFF); st(32'h10C, 32'h0);

        new_case("wrap_wait1", 1, 7, 38, 32'h1C, 0);
        ins(ienc(8, 0, 1, -1)); ins(ienc(8, 1, 2, 1)); ins(renc(1, 1, 3, 'h20)); ins(renc(1, 0, 4, 'h2A));
        ins(ienc(43, 0, 2, 'h100)); ins(ienc(43, 0, 3, 'h104)); ins(ienc(43, 0, 4, 'h108));
        st(32'h100, 32'h0); st(32'h104, 32'hFFFF_FFFE); st(32'h108, 32'h1);

        new_case("reg0_illegal", 0, 4, 14, 32'h10, 2);
        ins(ienc(8, 0, 0, 7)); ins(32'hFC00_0000); ins(renc(1, 2, 3, 'h21)); ins(ienc(43, 0, 0, 'h100));
        st(32'h100, 32'h0);

        new_case("beq", 0, 4, 14, 32'h14, 0);
        ins(ienc(8, 0, 1, 1)); ins(ienc(4, 1, 0, 2)); ins(ienc(4, 0, 0, 1));
        ins(ienc(43, 0, 1, 'h104)); ins(ienc(43, 0, 1, 'h100));
        st(32'h100, 32'h1);

        new_case("lw_sw_wait2", 2, 5, 37, 32'h14, 0);
        ins(ienc(8, 0, 7, 'h1234)); ins(ienc(43, 0, 7, 'h110)); ins(ienc(35, 0, 8, 'h110));
        ins(renc(8, 8, 9, 'h20)); ins(ienc(43, 0, 9, 'h114));
        st(32'h110, 32'h1234); st(32'h114, 32'h2468);

`ifdef MIPS_MC_JUMP_EN
        new_case("jump", 0, 1, 3, 32'h100, 0);
`else
        new_case("jump", 0, 1, 3, 32'h4, 1);
`endif
        ins(32'h0800_0040);

        for (int k = 0; k < n_tbl; k++) run_case(k);

        // stalled memory: every access waits 3 cycles; sw then lw through address 8
        assert_rst(3);
        pmem[0] = ienc(8, 0, 3, 2);
        pmem[1] = ienc(4, 0, 0, 3);
        pmem[5] = ienc(43, 0, 3, 8);
        pmem[6] = ienc(35, 0, 5, 8);
        pmem[7] = ienc(43, 0, 5, 'h108);
        exp_q.push_back({32'h8, 32'h2});
        exp_q.push_back({32'h108, 32'h2});
        cum = '{7, 13, 23, 34, 44};
        release_rst();
        for (int k = 1; k <= 5; k++) begin
            while ((retired < 32'(k)) && (cyc < 200)) step();
            check($sformatf("stall_retire%0d_cycle", k), 32'(cyc), 32'(cum[k-1]));
        end
        check("stall_pc", pc_out, 32'h20);
        check("stall_stores_missing", 32'(exp_q.size()), 32'd0);

        // beq-to-self loop at 0x10, then reset in the middle of a stalled fetch
        assert_rst(0);
        pmem[0] = ienc(4, 0, 0, 3);
        pmem[4] = ienc(4, 0, 0, -1);
        release_rst();
        #1;
        check("req_after_release", 32'(mem_req), 32'd1);
        while ((retired < 32'd1) && (cyc < 50)) step();
        check("loop_first_cycles", 32'(cyc), 32'd3);
        check("loop_first_pc", pc_out, 32'h10);
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            check($sformatf("loop_retired_%0d", k), retired, 32'(2 + k));
            check($sformatf("loop_pc_%0d", k), pc_out, 32'h10);
        end
        mem_wait = 4;
        step();
        step();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_req_drop", 32'(mem_req), 32'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_first_cycle", 32'(mem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
